slow_clock_monitor: RTL and testbench

//  Receiving end of the divided slow clock: takes a slow square wave (nominal 100 Hz) into the fast clock domain.

---
 rtl/slow_clock_pkg.sv | 17 +
 rtl/sync_edge_detect.sv | 27 ++
 rtl/slow_clock_monitor.sv | 143 ++++++++++++++
 tb/tb_slow_clock_monitor.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/slow_clock_pkg.sv
// Shared types and defaults for the slow clock monitor.
// Default timing targets a 100 Hz reference sampled by a 25 MHz system clock.
package slow_clock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_e;

    localparam int DEF_NOMINAL_PERIOD = 250000;
    localparam int DEF_TOLERANCE      = 2500;
    localparam int DEF_LOCK_COUNT     = 4;
    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_COUNT_WIDTH    = 20;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous level plus a rising-edge pulse.
// The pulse is combinational from the last sync flop and its delayed copy.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   delay_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            delay_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], async_i};
            delay_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~delay_q;

endmodule

// File: rtl/slow_clock_monitor.sv
// Measures a slow asynchronous square wave in fast-clock cycles and
// reports tick, period, lock, out-of-range and stall status.
module slow_clock_monitor
    import slow_clock_pkg::*;
#(
    parameter int NOMINAL_PERIOD = DEF_NOMINAL_PERIOD,
    parameter int TOLERANCE      = DEF_TOLERANCE,
    parameter int LOCK_COUNT     = DEF_LOCK_COUNT,
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int COUNT_WIDTH    = DEF_COUNT_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   slow_clock_in,
    output logic                   tick,
    output logic [COUNT_WIDTH-1:0] period,
    output logic                   period_valid,
    output logic                   locked,
    output logic                   too_fast,
    output logic                   too_slow,
    output logic                   stalled
);

    localparam int CW = COUNT_WIDTH;
    localparam int GW = $clog2(LOCK_COUNT + 1);

    // Limits are one bit wider than the counter so m never wraps.
    localparam logic [CW:0]   LO_LIM   = (CW+1)'(NOMINAL_PERIOD - TOLERANCE);
    localparam logic [CW:0]   HI_LIM   = (CW+1)'(NOMINAL_PERIOD + TOLERANCE);
    localparam logic [CW-1:0] STALL_AT = CW'(2 * NOMINAL_PERIOD - 1);
    localparam logic [GW-1:0] LC_V     = GW'(LOCK_COUNT);

    logic          rise;
    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [GW-1:0] good_q;
    logic [GW-1:0] good_inc;
    logic [CW:0]   m_full;
    logic [CW-1:0] m_sat;
    logic          in_range;
    logic          is_fast;
    logic          stall_hit;

    logic          tick_q;
    logic [CW-1:0] period_q;
    logic          period_valid_q;
    logic          locked_q;
    logic          too_fast_q;
    logic          too_slow_q;
    logic          stalled_q;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i  (clock),
        .rst_i  (reset),
        .async_i(slow_clock_in),
        .rise_o (rise)
    );

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (rise) begin
            cnt_d = '0;
        end else if (&cnt_q) begin
            cnt_d = cnt_q;
        end
    end

    assign m_full    = {1'b0, cnt_q} + (CW+1)'(1);
    assign m_sat     = m_full[CW] ? {CW{1'b1}} : m_full[CW-1:0];
    assign in_range  = (m_full >= LO_LIM) && (m_full <= HI_LIM);
    assign is_fast   = (m_full < LO_LIM);
    assign stall_hit = (cnt_q == STALL_AT);
    assign good_inc  = (good_q == LC_V) ? good_q : good_q + GW'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            good_q         <= '0;
            tick_q         <= 1'b0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            too_fast_q     <= 1'b0;
            too_slow_q     <= 1'b0;
            stalled_q      <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            tick_q         <= rise;
            period_valid_q <= 1'b0;
            too_fast_q     <= 1'b0;
            too_slow_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_q   <= ST_MEASURE;
                        stalled_q <= 1'b0;
                    end
                end
                ST_MEASURE, ST_LOCKED: begin
                    // An edge on the stall-threshold cycle is still measured.
                    if (rise) begin
                        period_q       <= m_sat;
                        period_valid_q <= 1'b1;
                        if (in_range) begin
                            good_q <= good_inc;
                            if (good_inc == LC_V) begin
                                state_q  <= ST_LOCKED;
                                locked_q <= 1'b1;
                            end
                        end else begin
                            too_fast_q <= is_fast;
                            too_slow_q <= ~is_fast;
                            good_q     <= '0;
                            state_q    <= ST_MEASURE;
                            locked_q   <= 1'b0;
                        end
                    end else if (stall_hit) begin
                        stalled_q <= 1'b1;
                        locked_q  <= 1'b0;
                        good_q    <= '0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tick         = tick_q;
    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign locked       = locked_q;
    assign too_fast     = too_fast_q;
    assign too_slow     = too_slow_q;
    assign stalled      = stalled_q;

endmodule

// File: tb/tb_slow_clock_monitor.sv
// Directed bench for slow_clock_monitor with a period_valid scoreboard.
// Small timing parameters: nominal 100 cycles, tolerance 2, lock after 3.
module tb_slow_clock_monitor;

    localparam int CW = 20;

    logic          clock;
    logic          reset;
    logic          slow_clock_in;
    logic          tick;
    logic [CW-1:0] period;
    logic          period_valid;
    logic          locked;
    logic          too_fast;
    logic          too_slow;
    logic          stalled;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int per;
        bit fast;
        bit slow;
        bit lock;
    } exp_t;

    exp_t sbq[$];

    slow_clock_monitor #(
        .NOMINAL_PERIOD(100),
        .TOLERANCE     (2),
        .LOCK_COUNT    (3),
        .SYNC_STAGES   (2),
        .COUNT_WIDTH   (CW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .slow_clock_in(slow_clock_in),
        .tick         (tick),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .too_fast     (too_fast),
        .too_slow     (too_slow),
        .stalled      (stalled)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int p, input bit f, input bit s, input bit l);
        exp_t e;
        e.per  = p;
        e.fast = f;
        e.slow = s;
        e.lock = l;
        sbq.push_back(e);
    endtask

    // One slow period of n cycles starting with a rise; call at a negedge.
    task automatic wave(input int n);
        slow_clock_in = 1'b1;
        repeat (n / 2) @(negedge clock);
        slow_clock_in = 1'b0;
        repeat (n - n / 2) @(negedge clock);
    endtask

    // Monitor: every period_valid pulse is matched against the scoreboard.
    always @(negedge clock) begin
        if (!reset && period_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_period_valid actual=%0d required=none at %0t",
                         period, $time);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("period", int'(period), e.per);
                chk("too_fast", int'(too_fast), int'(e.fast));
                chk("too_slow", int'(too_slow), int'(e.slow));
                chk("locked", int'(locked), int'(e.lock));
                chk("tick_with_pv", int'(tick), 1);
                chk("stalled_at_pv", int'(stalled), 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        slow_clock_in = 1'b0;

        // Reset held with the input toggling: everything stays quiet.
        for (int i = 0; i < 4; i++) begin
            repeat (3) @(negedge clock);
            slow_clock_in = ~slow_clock_in;
            chk("reset_outputs",
                int'({tick, period_valid, locked, too_fast, too_slow, stalled}), 0);
            chk("reset_period", int'(period), 0);
        end
        @(negedge clock);
        slow_clock_in = 1'b0;
        reset         = 1'b0;
        repeat (5) @(negedge clock);

        // First rise: tick three cycles later, no period report.
        slow_clock_in = 1'b1;
        repeat (2) @(negedge clock);
        chk("tick_early", int'(tick), 0);
        @(negedge clock);
        chk("tick_latency", int'(tick), 1);
        repeat (47) @(negedge clock);
        slow_clock_in = 1'b0;
        repeat (50) @(negedge clock);

        // Nominal periods: lock on the fourth edge.
        push(100, 0, 0, 0); wave(100);
        push(100, 0, 0, 0); wave(100);
        push(100, 0, 0, 1); wave(97);
        // Short period, then relock on the lower inclusive bound.
        push(97, 1, 0, 0);  wave(98);
        push(98, 0, 0, 0);  wave(98);
        push(98, 0, 0, 0);  wave(98);
        push(98, 0, 0, 1);  wave(103);
        // Long period, then the upper inclusive bound.
        push(103, 0, 1, 0); wave(102);
        push(102, 0, 0, 0); wave(100);
        push(100, 0, 0, 0); wave(100);
        push(100, 0, 0, 1); wave(100);

        // Input held low: stall exactly 200 cycles after the tick.
        repeat (102) @(negedge clock);
        chk("stall_early", int'(stalled), 0);
        chk("locked_before_stall", int'(locked), 1);
        @(negedge clock);
        chk("stall_set", int'(stalled), 1);
        chk("locked_after_stall", int'(locked), 0);
        repeat (20) @(negedge clock);
        chk("stall_hold", int'(stalled), 1);

        // Resume: stalled clears on the first edge, which is not measured.
        slow_clock_in = 1'b1;
        repeat (2) @(negedge clock);
        chk("stall_before_edge", int'(stalled), 1);
        @(negedge clock);
        chk("stall_cleared", int'(stalled), 0);
        repeat (97) @(negedge clock);
        slow_clock_in = 1'b0;
        repeat (100) @(negedge clock);
        // A 200-cycle period lands on the stall threshold: edge wins.
        push(200, 0, 1, 0); wave(100);
        push(100, 0, 0, 0); wave(100);
        push(100, 0, 0, 0); wave(100);
        push(100, 0, 0, 1); wave(100);
        chk("relocked", int'(locked), 1);
        chk("period_before_reset", int'(period), 100);

        // Async reset between clock edges clears state immediately.
        #2;
        reset = 1'b1;
        #1;
        chk("async_locked", int'(locked), 0);
        chk("async_period", int'(period), 0);
        chk("async_stalled", int'(stalled), 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        // After reset the first edge is unmeasured again.
        wave(100);
        push(100, 0, 0, 0); wave(10);
        repeat (20) @(negedge clock);
        chk("scoreboard_drained", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
